// File: rtl/cpu_6502_fetch_decode_pkg.sv
// rtl/cpu_6502_fetch_decode_pkg.sv - shared types and constants for the 6502 fetch/decode front end
package cpu_6502_fetch_decode_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DEC,
    LO,
    HI,
    HOLD
  } fetch_state_t;

  // IMPLIED is encoded as zero so a cleared instruction register reads as IMPLIED
  typedef enum logic [3:0] {
    IMPLIED,
    ACCUMULATOR,
    IMMEDIATE,
    ZERO_PAGE,
    ZERO_PAGE_X,
    ZERO_PAGE_Y,
    ABSOLUTE,
    ABSOLUTE_X,
    ABSOLUTE_Y,
    ABSOLUTE_INDIRECT,
    INDIRECT_X,
    INDIRECT_Y,
    RELATIVE
  } addressing_mode_t;

  localparam logic [7:0] OP_JSR       = 8'h20;
  localparam logic [7:0] OP_JMP_ABS   = 8'h4C;
  localparam logic [7:0] OP_JMP_IND   = 8'h6C;
  // conditional branches are xxy10000
  localparam logic [7:0] BRANCH_MASK  = 8'h1F;
  localparam logic [7:0] BRANCH_MATCH = 8'h10;

  function automatic logic [1:0] mode_len(input addressing_mode_t mode);
    case (mode)
      IMPLIED, ACCUMULATOR:                               mode_len = 2'd1;
      ABSOLUTE, ABSOLUTE_X, ABSOLUTE_Y, ABSOLUTE_INDIRECT: mode_len = 2'd3;
      default:                                            mode_len = 2'd2;
    endcase
  endfunction

  // single-byte opcodes with no operand (stack, flag, transfer, inc/dec register, NOP, BRK, RTI, RTS)
  function automatic logic is_implied(input logic [7:0] op);
    case (op)
      8'h00, 8'h40, 8'h60, 8'h08, 8'h18, 8'h28, 8'h38, 8'h48, 8'h58,
      8'h68, 8'h78, 8'h88, 8'h98, 8'hA8, 8'hB8, 8'hC8, 8'hD8, 8'hE8,
      8'hF8, 8'h8A, 8'h9A, 8'hAA, 8'hBA, 8'hCA, 8'hEA: is_implied = 1'b1;
      default:                                        is_implied = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_6502_opcode_decoder.sv
// rtl/cpu_6502_opcode_decoder.sv - combinational opcode to addressing mode / length / legality decode
module cpu_6502_opcode_decoder
  import cpu_6502_fetch_decode_pkg::*;
(
  input  logic [7:0]       opcode,
  output addressing_mode_t addr_mode,
  output logic [1:0]       num_bytes,
  output logic             illegal
);

  logic [2:0]       aaa;
  logic [2:0]       bbb;
  logic [1:0]       cc;
  addressing_mode_t mode;
  logic             legal;

  assign aaa = opcode[7:5];
  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  // special opcodes first, then the aaa/bbb/cc group tables; illegal opcodes fall back to 1-byte IMPLIED
  always_comb begin
    mode  = IMPLIED;
    legal = 1'b0;
    if (is_implied(opcode)) begin
      legal = 1'b1;
    end else if (opcode == OP_JSR || opcode == OP_JMP_ABS) begin
      mode  = ABSOLUTE;
      legal = 1'b1;
    end else if (opcode == OP_JMP_IND) begin
      mode  = ABSOLUTE_INDIRECT;
      legal = 1'b1;
    end else if ((opcode & BRANCH_MASK) == BRANCH_MATCH) begin
      mode  = RELATIVE;
      legal = 1'b1;
    end else begin
      case (cc)
        2'b01: begin
          legal = 1'b1;
          case (bbb)
            3'd0: mode = INDIRECT_X;
            3'd1: mode = ZERO_PAGE;
            3'd2: begin
              mode  = IMMEDIATE;
              legal = (aaa != 3'd4);
            end
            3'd3: mode = ABSOLUTE;
            3'd4: mode = INDIRECT_Y;
            3'd5: mode = ZERO_PAGE_X;
            3'd6: mode = ABSOLUTE_Y;
            default: mode = ABSOLUTE_X;
          endcase
        end
        2'b10: begin
          case (bbb)
            3'd0: begin
              mode  = IMMEDIATE;
              legal = (aaa == 3'd5);
            end
            3'd1: begin
              mode  = ZERO_PAGE;
              legal = 1'b1;
            end
            3'd2: begin
              mode  = ACCUMULATOR;
              legal = !aaa[2];
            end
            3'd3: begin
              mode  = ABSOLUTE;
              legal = 1'b1;
            end
            3'd5: begin
              mode  = (aaa[2:1] == 2'b10) ? ZERO_PAGE_Y : ZERO_PAGE_X;
              legal = 1'b1;
            end
            3'd7: begin
              mode  = (aaa == 3'd5) ? ABSOLUTE_Y : ABSOLUTE_X;
              legal = (aaa != 3'd4);
            end
            default: legal = 1'b0;
          endcase
        end
        2'b00: begin
          case (aaa)
            3'd1: begin
              if (bbb == 3'd1) begin
                mode  = ZERO_PAGE;
                legal = 1'b1;
              end else if (bbb == 3'd3) begin
                mode  = ABSOLUTE;
                legal = 1'b1;
              end
            end
            3'd4, 3'd5: begin
              case (bbb)
                3'd0: begin
                  mode  = IMMEDIATE;
                  legal = (aaa == 3'd5);
                end
                3'd1: begin
                  mode  = ZERO_PAGE;
                  legal = 1'b1;
                end
                3'd3: begin
                  mode  = ABSOLUTE;
                  legal = 1'b1;
                end
                3'd5: begin
                  mode  = ZERO_PAGE_X;
                  legal = 1'b1;
                end
                3'd7: begin
                  mode  = ABSOLUTE_X;
                  legal = (aaa == 3'd5);
                end
                default: legal = 1'b0;
              endcase
            end
            3'd6, 3'd7: begin
              case (bbb)
                3'd0: begin
                  mode  = IMMEDIATE;
                  legal = 1'b1;
                end
                3'd1: begin
                  mode  = ZERO_PAGE;
                  legal = 1'b1;
                end
                3'd3: begin
                  mode  = ABSOLUTE;
                  legal = 1'b1;
                end
                default: legal = 1'b0;
              endcase
            end
            default: legal = 1'b0;
          endcase
        end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      mode = IMPLIED;
    end
  end

  assign addr_mode = mode;
  assign num_bytes = mode_len(mode);
  assign illegal   = !legal;

endmodule

// File: rtl/cpu_6502_fetch_decode.sv
// rtl/cpu_6502_fetch_decode.sv - 6502 instruction fetch and decode front end with flush support
module cpu_6502_fetch_decode
  import cpu_6502_fetch_decode_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h8000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [7:0]        opcode_o,
  output addressing_mode_t  addr_mode_o,
  output logic [15:0]       operand_o,
  output logic [1:0]        num_bytes_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              illegal_o
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [7:0]        opcode_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;
  addressing_mode_t  mode_q;
  logic [1:0]        len_q;
  logic              illegal_q;

  addressing_mode_t  dec_mode;
  logic [1:0]        dec_len;
  logic              dec_illegal;

  logic              rd;
  logic [ADDR_W-1:0] rd_addr;
  logic              valid;
  logic              handshake;
  logic [ADDR_W-1:0] len_ext;

  // decode straight off the memory bus so the DEC cycle already knows how many operand reads follow
  cpu_6502_opcode_decoder u_decoder (
    .opcode    (mem_data_i),
    .addr_mode (dec_mode),
    .num_bytes (dec_len),
    .illegal   (dec_illegal)
  );

  assign len_ext   = ADDR_W'(len_q);
  assign handshake = (state_q == HOLD) && instr_ready_i;

  // fetch state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and memory read issue; flush overrides everything and suppresses any read
  always_comb begin
    state_d = state_q;
    rd      = 1'b0;
    rd_addr = pc_q;
    valid   = 1'b0;
    case (state_q)
      FETCH: begin
        rd      = 1'b1;
        state_d = DEC;
      end
      DEC: begin
        if (dec_len == 2'd1) begin
          state_d = HOLD;
        end else begin
          rd      = 1'b1;
          rd_addr = pc_q + ADDR_W'(1);
          state_d = LO;
        end
      end
      LO: begin
        if (len_q == 2'd3) begin
          rd      = 1'b1;
          rd_addr = pc_q + ADDR_W'(2);
          state_d = HI;
        end else begin
          state_d = HOLD;
        end
      end
      HI: begin
        state_d = HOLD;
      end
      HOLD: begin
        valid = 1'b1;
        if (instr_ready_i) begin
          rd      = 1'b1;
          rd_addr = pc_q + len_ext;
          state_d = DEC;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (flush_i) begin
      state_d = FETCH;
      rd      = 1'b0;
    end
  end

  // pc and instruction capture; a flush drops whatever byte is on the bus this cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_pc_q <= '0;
      opcode_q   <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      mode_q     <= IMPLIED;
      len_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        pc_q <= flush_pc_i;
      end else if (handshake) begin
        pc_q <= pc_q + len_ext;
      end
      if (!flush_i) begin
        case (state_q)
          DEC: begin
            opcode_q   <= mem_data_i;
            mode_q     <= dec_mode;
            len_q      <= dec_len;
            illegal_q  <= dec_illegal;
            instr_pc_q <= pc_q;
            lo_q       <= '0;
            hi_q       <= '0;
          end
          LO:      lo_q <= mem_data_i;
          HI:      hi_q <= mem_data_i;
          default: ;
        endcase
      end
    end
  end

  // reset gates the read strobe so nothing is requested while reset is held
  assign mem_rd_o      = rd && rst_n;
  assign mem_addr_o    = rd_addr;
  assign instr_valid_o = valid;
  assign opcode_o      = opcode_q;
  assign addr_mode_o   = mode_q;
  assign num_bytes_o   = len_q;
  assign pc_o          = instr_pc_q;
  assign illegal_o     = illegal_q;
  assign operand_o     = (len_q == 2'd3) ? {hi_q, lo_q} :
                         (len_q == 2'd2) ? {8'h00, lo_q} : 16'h0000;

endmodule

// File: doc/cpu_6502_fetch_decode.md
Name: cpu_6502_fetch_decode

Overview:
- Front end of the 6502 core: reads the byte stream from program memory and decodes each instruction.
- Reads the opcode, decodes addressing mode and length, reads 0-2 operand bytes, and presents the assembled instruction to the control unit over a valid/ready handshake.
- Supports redirect (flush) for jumps, branches and interrupts.
- Sits between the program memory port and the control FSM.

Parameters:
RESET_PC, 16'h8000, PC loaded on reset
ADDR_W, 16, memory address width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
mem_rd_o  out  1  read strobe to program memory
mem_addr_o  out  ADDR_W  read address, valid when mem_rd_o=1
mem_data_i  in  8  read data, valid exactly 1 cycle after mem_rd_o
flush_i  in  1  abandon current fetch and redirect
flush_pc_i  in  ADDR_W  redirect target
instr_valid_o  out  1  decoded instruction available
instr_ready_i  in  1  consumer accepts instruction
opcode_o  out  8  raw opcode
addr_mode_o  out  addressing_mode_t  decoded addressing mode
operand_o  out  16  operand: 0 (1-byte), {8'h00,lo} (2-byte), {hi,lo} (3-byte)
num_bytes_o  out  2  instruction length 1..3
pc_o  out  ADDR_W  address of opcode byte
illegal_o  out  1  opcode not in supported set

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - state=FETCH, pc=RESET_PC.
  - All outputs 0 except mem_addr_o=RESET_PC.
  - Reset mid-instruction discards all partial state.
- FSM states: FETCH, DEC, LO, HI, HOLD.
- FETCH: mem_rd_o=1, addr=pc → DEC.
- DEC:
  - Capture mem_data_i as opcode and decode it combinationally.
  - len=1 → HOLD.
  - len≥2 → issue read pc+1 this cycle → LO.
- LO:
  - Capture lo byte.
  - len=3 → issue read pc+2 → HI; else → HOLD.
- HI: capture hi byte → HOLD.
- HOLD:
  - instr_valid_o=1; all instruction outputs stable until handshake.
  - On valid&ready: pc ← pc+num_bytes (mod 2^16, FFFF+1=0000).
  - Read of the new pc is issued in the same cycle → DEC.
  - Sustained throughput: 1-byte instruction every 2 cycles.
- Latency from FETCH to instr_valid_o: 2 cycles (1 byte), 3 (2 bytes), 4 (3 bytes).
- Operand addresses pc+1 and pc+2 wrap modulo 2^16.
- flush_i has highest priority in any state:
  - Next cycle: state=FETCH, pc=flush_pc_i, instr_valid_o=0.
  - Data returning for an abandoned read is ignored.
  - Flush coincident with a handshake: the instruction counts as consumed; pc takes flush_pc_i, not pc+len.
- Decode rules (opcode = aaa bbb cc):
  - Implied list (00,40,60,08,18,28,38,48,58,68,78,88,98,A8,B8,C8,D8,E8,F8,8A,9A,AA,BA,CA,EA): IMPLIED, 1 byte.
  - cc=01 bbb: IND1_X→INDIRECT_X, ZPG→ZERO_PAGE, IMM→IMMEDIATE, ABS→ABSOLUTE, IND2_Y→INDIRECT_Y, ZPG_X→ZERO_PAGE_X, ABS_Y→ABSOLUTE_Y, ABS_X→ABSOLUTE_X. STA+IMM (89) is illegal.
  - cc=10:
    - Same bbb map; ACC→ACCUMULATOR only for aaa<4.
    - IMM legal only for LDX (A2).
    - STX/LDX: ZPG_X→ZERO_PAGE_Y; LDX ABS_X→ABSOLUTE_Y.
    - STX ABS_X is illegal.
  - cc=00:
    - BIT: ZPG/ABS only.
    - JMP 4C: ABSOLUTE. JMP (ind) 6C: ABSOLUTE_INDIRECT.
    - STY, LDY, CPY, CPX per G3 bbb.
    - IMM only for A0, C0, E0.
    - STY ABS_X illegal; CPY/CPX only IMM/ZPG/ABS.
    - JSR 20: ABSOLUTE.
    - Branches xxy10000: RELATIVE.
  - Length: 1 for IMPLIED/ACCUMULATOR; 3 for ABSOLUTE*/ABSOLUTE_INDIRECT; else 2.
  - Anything else: illegal_o=1, IMPLIED, 1 byte. Still delivered; the consumer decides what to do.

Decomposition:
- Package gets: fetch state enum fetch_state_t (FETCH, DEC, LO, HI, HOLD), JSR and JMP opcode constants, branch mask constants.
- Sub-module cpu_6502_opcode_decoder (purely combinational): opcode → addr_mode, num_bytes, illegal. Reused by the bench as a reference.

Test Plan:
- Reset, memory[8000]=EA → after 2 cycles: instr_valid_o=1, opcode EA, IMPLIED, len 1, pc_o 8000, operand 0.
- mem[8000..8002]=1D 34 12, ready=1 → ABSOLUTE_X, operand 1234, len 3, valid at cycle 4; next mem_addr_o=8003.
- B6 20 → ZERO_PAGE_Y, operand 0020. A2 05 → IMMEDIATE. 89 → illegal_o=1, len 1.
- Hold ready=0 for 5 cycles in HOLD → outputs stable, no mem_rd_o; ready=1 → pc advances by len.
- flush_i in LO with flush_pc_i=C000 → valid stays 0, next mem_addr_o=C000, stale lo byte discarded; flush coincident with handshake → pc=C000.
- pc=FFFF, opcode AD with operands at 0000, 0001 → operand correct, next pc=0002.
